// File: rtl/fast_score_pipe.sv
// fast_score_pipe
// ---------------------------------------------------------------------------
// Pipelined FAST corner-score unit. One beat per cycle carries a centre pixel,
// its 16-pixel Bresenham ring, a threshold and an address tag. The ring is
// classified (dark / bright / similar), a circular contiguous-arc test decides
// cornerness, and the score is the larger of the bright and dark sums
// (0 for a non-corner). A running corner count is kept.
//
// Build option:
//   FAST_SAD_SCORE_EN  defined   -> each classified pixel contributes its
//                                   absolute difference beyond ref+/-th
//                                   (unclipped, floored at 0)
//                      undefined -> each classified pixel contributes its raw
//                                   value p
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready input handshake; in_ready = pipe advance enable
//   ref_pxl           centre pixel
//   ring_pxl          ring pixel k at [k*PIXEL_W +: PIXEL_W], k=0..15 clockwise
//   threshold         FAST threshold
//   ref_addr          address tag, passed through unchanged
//   out_valid/out_ready output handshake
//   out_ref_pxl, out_ref_addr, out_score, out_is_corner   result fields
//   cnt_clr           clears the corner counter
//   corner_cnt        corners transferred out since reset or last clear
//
// Handshake: a beat moves on a clock edge where valid && ready are both high.
// All three stages advance together when adv = !out_valid || out_ready, so a
// stalled output holds every output field and freezes the stages behind it.
// Latency is 3 cycles from accept to out_valid.
// ---------------------------------------------------------------------------
module fast_score_pipe #(
    parameter int PIXEL_W = 8,
    parameter int ADDR_W  = 15,
    parameter int ARC_LEN = 9,
    parameter int SCORE_W = PIXEL_W + 4,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PIXEL_W-1:0]     ref_pxl,
    input  logic [16*PIXEL_W-1:0]  ring_pxl,
    input  logic [PIXEL_W-1:0]     threshold,
    input  logic [ADDR_W-1:0]      ref_addr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PIXEL_W-1:0]     out_ref_pxl,
    output logic [ADDR_W-1:0]      out_ref_addr,
    output logic [SCORE_W-1:0]     out_score,
    output logic                   out_is_corner,
    input  logic                   cnt_clr,
    output logic [CNT_W-1:0]       corner_cnt
);

    localparam logic [PIXEL_W:0] PIX_MAX = {1'b0, {PIXEL_W{1'b1}}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // True when m holds a run of at least ARC_LEN ones, wrapping bit 15 -> 0.
    function automatic logic has_arc(input logic [15:0] m);
        logic       found;
        logic       run;
        logic [3:0] idx;
        found = 1'b0;
        for (int s = 0; s < 16; s++) begin
            run = 1'b1;
            for (int k = 0; k < ARC_LEN; k++) begin
                idx = 4'(s + k);
                run = run & m[idx];
            end
            found = found | run;
        end
        return found;
    endfunction

    logic w_adv;
    logic w_accept;
    assign w_adv    = !out_valid || out_ready;
    assign w_accept = in_valid && w_adv;
    assign in_ready = w_adv;

    // ---------------- Stage 1: clip bounds and classification ----------------
    logic [PIXEL_W:0] w_sum_hi;
    logic [PIXEL_W:0] w_clip_high;
    logic [PIXEL_W:0] w_clip_low;
    logic [15:0]      w_bright;
    logic [15:0]      w_dark;

    assign w_sum_hi    = {1'b0, ref_pxl} + {1'b0, threshold};
    assign w_clip_high = (w_sum_hi > PIX_MAX) ? PIX_MAX : w_sum_hi;
    assign w_clip_low  = (ref_pxl >= threshold) ? {1'b0, ref_pxl - threshold} : '0;

    always_comb begin : p_classify
        logic [PIXEL_W:0] p;
        w_bright = '0;
        w_dark   = '0;
        p        = '0;
        for (int k = 0; k < 16; k++) begin
            p = {1'b0, ring_pxl[k*PIXEL_W +: PIXEL_W]};
            // Dark takes priority so that th=0 splits the ring cleanly at ref.
            w_dark[k]   = (p <= w_clip_low);
            w_bright[k] = !w_dark[k] && (p >= w_clip_high);
        end
    end

    logic                  r1_valid;
    logic [15:0]           r1_bright;
    logic [15:0]           r1_dark;
    logic [16*PIXEL_W-1:0] r1_ring;
    logic [PIXEL_W-1:0]    r1_ref;
    logic [ADDR_W-1:0]     r1_addr;
`ifdef FAST_SAD_SCORE_EN
    logic [PIXEL_W-1:0]    r1_th;
`endif

    always_ff @(posedge clk) begin
        if (rst)        r1_valid <= 1'b0;
        else if (w_adv) r1_valid <= w_accept;
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r1_bright <= w_bright;
            r1_dark   <= w_dark;
            r1_ring   <= ring_pxl;
            r1_ref    <= ref_pxl;
            r1_addr   <= ref_addr;
`ifdef FAST_SAD_SCORE_EN
            r1_th     <= threshold;
`endif
        end
    end

    // ---------------- Stage 2: sums and arc test ----------------
    logic [SCORE_W-1:0] w_bright_sum;
    logic [SCORE_W-1:0] w_dark_sum;
    logic               w_corner;

    always_comb begin : p_sums
        logic [PIXEL_W-1:0]   p;
`ifdef FAST_SAD_SCORE_EN
        logic signed [PIXEL_W+1:0] v_db;
        logic signed [PIXEL_W+1:0] v_dd;
        v_db = '0;
        v_dd = '0;
`endif
        w_bright_sum = '0;
        w_dark_sum   = '0;
        p            = '0;
        for (int k = 0; k < 16; k++) begin
            p = r1_ring[k*PIXEL_W +: PIXEL_W];
`ifdef FAST_SAD_SCORE_EN
            // Differences against the unclipped bounds; a negative result
            // (possible when ref+th saturated) contributes nothing.
            v_db = $signed({2'b00, p}) - $signed({2'b00, r1_ref}) - $signed({2'b00, r1_th});
            v_dd = $signed({2'b00, r1_ref}) - $signed({2'b00, p}) - $signed({2'b00, r1_th});
            if (r1_bright[k] && !v_db[PIXEL_W+1])
                w_bright_sum = w_bright_sum + {{(SCORE_W-PIXEL_W){1'b0}}, v_db[PIXEL_W-1:0]};
            if (r1_dark[k] && !v_dd[PIXEL_W+1])
                w_dark_sum = w_dark_sum + {{(SCORE_W-PIXEL_W){1'b0}}, v_dd[PIXEL_W-1:0]};
`else
            if (r1_bright[k])
                w_bright_sum = w_bright_sum + {{(SCORE_W-PIXEL_W){1'b0}}, p};
            if (r1_dark[k])
                w_dark_sum = w_dark_sum + {{(SCORE_W-PIXEL_W){1'b0}}, p};
`endif
        end
    end

    assign w_corner = has_arc(r1_bright) || has_arc(r1_dark);

    logic               r2_valid;
    logic [SCORE_W-1:0] r2_bright_sum;
    logic [SCORE_W-1:0] r2_dark_sum;
    logic               r2_corner;
    logic [PIXEL_W-1:0] r2_ref;
    logic [ADDR_W-1:0]  r2_addr;

    always_ff @(posedge clk) begin
        if (rst)        r2_valid <= 1'b0;
        else if (w_adv) r2_valid <= r1_valid;
    end

    always_ff @(posedge clk) begin
        if (w_adv && r1_valid) begin
            r2_bright_sum <= w_bright_sum;
            r2_dark_sum   <= w_dark_sum;
            r2_corner     <= w_corner;
            r2_ref        <= r1_ref;
            r2_addr       <= r1_addr;
        end
    end

    // ---------------- Stage 3: score select and output register ----------------
    logic [SCORE_W-1:0] w_score;
    // Ties pick bright_sum, which is the same value.
    assign w_score = !r2_corner ? '0 :
                     (r2_dark_sum > r2_bright_sum) ? r2_dark_sum : r2_bright_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_ref_pxl   <= '0;
            out_ref_addr  <= '0;
            out_score     <= '0;
            out_is_corner <= 1'b0;
        end else if (w_adv) begin
            out_valid <= r2_valid;
            if (r2_valid) begin
                out_ref_pxl   <= r2_ref;
                out_ref_addr  <= r2_addr;
                out_score     <= w_score;
                out_is_corner <= r2_corner;
            end
        end
    end

    // ---------------- Corner counter ----------------
    logic w_corner_xfer;
    assign w_corner_xfer = out_valid && out_ready && out_is_corner;

    always_ff @(posedge clk) begin
        if (rst) begin
            corner_cnt <= '0;
        end else if (cnt_clr) begin
            // A clear coinciding with a corner transfer still counts that corner.
            corner_cnt <= w_corner_xfer ? CNT_W'(1) : '0;
        end else if (w_corner_xfer && (corner_cnt != CNT_MAX)) begin
            corner_cnt <= corner_cnt + CNT_W'(1);
        end
    end

endmodule
